// File: rtl/sp_ram_param.sv
// Parametrised single-port synchronous RAM with byte-enable writes, selectable
// read/write modes and a fill engine that writes FILL_VALUE to every word.
module sp_ram_param #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 8,
    parameter int                READ_MODE  = 0,
    parameter int                WRITE_MODE = 0,
    parameter logic [DATA_W-1:0] FILL_VALUE = '0,
    parameter bit                AUTO_FILL  = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                ce,
    input  logic                wre,
    input  logic [ADDR_W-1:0]   ad,
    input  logic [DATA_W-1:0]   din,
    input  logic [DATA_W/8-1:0] be,
    input  logic                oce,
    input  logic                fill_req,
    output logic [DATA_W-1:0]   dout,
    output logic                dout_vld,
    output logic                busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int NB    = DATA_W / 8;

    typedef enum logic {IDLE, FILL} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] fill_addr, fill_addr_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              access;
    logic              new_valid;
    logic              mem_we;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [NB-1:0]     wr_be;

    logic [DATA_W-1:0] s1_data;
    logic              s1_vld;

    assign busy      = (state == FILL);
    assign access    = reset_n && !busy && ce;
    // Writes only produce an output word when the write mode asks for one.
    assign new_valid = access && (!wre || WRITE_MODE != 0);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= AUTO_FILL ? FILL : IDLE;
            fill_addr <= '0;
        end else begin
            state     <= state_nxt;
            fill_addr <= fill_addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_addr_nxt = fill_addr;
        case (state)
            IDLE: begin
                if (fill_req)
                    state_nxt = FILL;
            end
            FILL: begin
                fill_addr_nxt = fill_addr + 1'b1;
                if (&fill_addr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The fill engine and user writes share the single RAM port.
    always_comb begin
        if (busy) begin
            mem_we  = reset_n;
            wr_addr = fill_addr;
            wr_data = FILL_VALUE;
            wr_be   = '1;
        end else begin
            mem_we  = access && wre;
            wr_addr = ad;
            wr_data = din;
            wr_be   = be;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            for (int i = 0; i < NB; i++)
                if (wr_be[i])
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
    end

    // Stage 1 reads the pre-write word; write-through merges the enabled lanes.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_data <= '0;
            s1_vld  <= 1'b0;
        end else begin
            if (new_valid)
                for (int i = 0; i < NB; i++)
                    s1_data[8*i +: 8] <= (wre && WRITE_MODE == 1 && be[i]) ?
                                         din[8*i +: 8] : mem[ad][8*i +: 8];
            s1_vld <= new_valid || (READ_MODE == 1 && s1_vld && !oce);
        end
    end

    generate
        if (READ_MODE == 1) begin : g_pipe
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    dout     <= '0;
                    dout_vld <= 1'b0;
                end else if (oce) begin
                    dout     <= s1_data;
                    dout_vld <= s1_vld;
                end else begin
                    dout_vld <= 1'b0;
                end
            end
        end else begin : g_bypass
            assign dout     = s1_data;
            assign dout_vld = s1_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_param.sv
// Randomised and directed bench for sp_ram_param: three configurations share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_sp_ram_param;

    localparam int          AW     = 8;
    localparam int          DEPTH  = 2 ** AW;
    localparam logic [31:0] FILL_A = 32'hA5A5_A5A5;
    localparam logic [31:0] FILL_B = 32'h1234_5678;
    localparam logic [7:0]  FILL_C = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n, ce, wre, oce, fill_req;
    logic [AW-1:0] ad;
    logic [31:0]   din;
    logic [3:0]    be;

    logic [31:0] dout_a, dout_b;
    logic [7:0]  dout_c;
    logic        vld_a, vld_b, vld_c;
    logic        busy_a, busy_b, busy_c;

    // A: bypass read, read-before-write, auto fill
    sp_ram_param #(.DATA_W(32), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(2),
                   .FILL_VALUE(FILL_A), .AUTO_FILL(1'b1)) u_a (
        .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .ad(ad), .din(din),
        .be(be), .oce(oce), .fill_req(fill_req), .dout(dout_a),
        .dout_vld(vld_a), .busy(busy_a));

    // B: pipelined read, write-through, fill only on request
    sp_ram_param #(.DATA_W(32), .ADDR_W(AW), .READ_MODE(1), .WRITE_MODE(1),
                   .FILL_VALUE(FILL_B), .AUTO_FILL(1'b0)) u_b (
        .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .ad(ad), .din(din),
        .be(be), .oce(oce), .fill_req(fill_req), .dout(dout_b),
        .dout_vld(vld_b), .busy(busy_b));

    // C: 8-bit, bypass read, normal write, auto fill
    sp_ram_param #(.DATA_W(8), .ADDR_W(AW), .READ_MODE(0), .WRITE_MODE(0),
                   .FILL_VALUE(FILL_C), .AUTO_FILL(1'b1)) u_c (
        .clk(clk), .reset_n(reset_n), .ce(ce), .wre(wre), .ad(ad), .din(din[7:0]),
        .be(be[0:0]), .oce(oce), .fill_req(fill_req), .dout(dout_c),
        .dout_vld(vld_c), .busy(busy_c));

    int          rm [3] = '{0, 1, 0};
    int          wm [3] = '{2, 1, 0};
    bit          af [3] = '{1'b1, 1'b0, 1'b1};
    int          nb [3] = '{4, 4, 1};
    logic [31:0] fv [3] = '{FILL_A, FILL_B, {24'h0, FILL_C}};

    logic [31:0] m_mem  [3][DEPTH];
    logic [31:0] m_dout [3];
    logic [31:0] m_s1   [3];
    bit          m_vld  [3];
    bit          m_s1v  [3];
    bit          m_fill [3];
    int          m_fpos [3];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int busy_cnt_a  = 0;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, act, exp);
        end
    endtask

    // One clock of the behavioural model for configuration k.
    task automatic modelStep(input int k);
        logic [31:0] old_w, new_w, res;
        bit          has;
        if (!reset_n) begin
            m_dout[k] = '0;
            m_vld[k]  = 1'b0;
            m_s1[k]   = '0;
            m_s1v[k]  = 1'b0;
            m_fill[k] = af[k];
            m_fpos[k] = 0;
            return;
        end
        has = 1'b0;
        res = '0;
        if (m_fill[k]) begin
            m_mem[k][m_fpos[k]] = fv[k];
            m_fpos[k]++;
            if (m_fpos[k] == DEPTH) begin
                m_fill[k] = 1'b0;
                m_fpos[k] = 0;
            end
        end else begin
            if (ce) begin
                old_w = m_mem[k][ad];
                if (wre) begin
                    new_w = old_w;
                    for (int i = 0; i < nb[k]; i++)
                        if (be[i]) new_w[8*i +: 8] = din[8*i +: 8];
                    m_mem[k][ad] = new_w;
                    has = (wm[k] != 0);
                    res = (wm[k] == 1) ? new_w : old_w;
                end else begin
                    has = 1'b1;
                    res = old_w;
                end
            end
            if (fill_req) m_fill[k] = 1'b1;
        end
        if (rm[k] == 0) begin
            m_vld[k] = has;
            if (has) m_dout[k] = res;
        end else begin
            if (oce) begin
                m_dout[k] = m_s1[k];
                m_vld[k]  = m_s1v[k];
            end else begin
                m_vld[k] = 1'b0;
            end
            if (has) begin
                m_s1[k]  = res;
                m_s1v[k] = 1'b1;
            end else if (oce) begin
                m_s1v[k] = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic w,
                                 input logic [AW-1:0] a, input logic [31:0] d,
                                 input logic [3:0] b, input logic o, input logic f);
        reset_n  = r;
        ce       = c;
        wre      = w;
        ad       = a;
        din      = d;
        be       = b;
        oce      = o;
        fill_req = f;
        @(posedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) modelStep(k);
        #1;
        if (busy_a) busy_cnt_a++;
        checkOutput("a_dout", dout_a, m_dout[0]);
        checkOutput("a_vld", 32'(vld_a), 32'(m_vld[0]));
        checkOutput("a_busy", 32'(busy_a), 32'(m_fill[0]));
        checkOutput("b_dout", dout_b, m_dout[1]);
        checkOutput("b_vld", 32'(vld_b), 32'(m_vld[1]));
        checkOutput("b_busy", 32'(busy_b), 32'(m_fill[1]));
        checkOutput("c_dout", 32'(dout_c), m_dout[2]);
        checkOutput("c_vld", 32'(vld_c), 32'(m_vld[2]));
        checkOutput("c_busy", 32'(busy_c), 32'(m_fill[2]));
        @(negedge clk);
    endtask

    task automatic idleCycles(input int n, input logic o);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, o, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] rd_addrs [3];
        rd_addrs = '{8'h00, 8'h7F, 8'hFF};
        reset_n = 1'b0; ce = 1'b0; wre = 1'b0; ad = '0; din = '0; be = '0;
        oce = 1'b1; fill_req = 1'b0;
        @(negedge clk);

        // Reset, then count the auto-fill pass of A while B gets a requested fill
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        busy_cnt_a = 0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        checkOutput("rst_dout_a", dout_a, 32'h0);
        checkOutput("rst_vld_a", 32'(vld_a), 32'h0);
        checkOutput("rst_busy_a", 32'(busy_a), 32'h1);
        checkOutput("rst_busy_b", 32'(busy_b), 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        for (int i = 0; i < 3 * DEPTH && busy_a; i++)
            applyStimulus(1'b1, 1'($urandom), 1'b0, 8'($urandom), $urandom, 4'($urandom),
                          1'b1, (i == 10));
        checkOutput("fill_len_a", 32'(busy_cnt_a), 32'(DEPTH));
        idleCycles(2, 1'b1);

        foreach (rd_addrs[j]) begin
            applyStimulus(1'b1, 1'b1, 1'b0, rd_addrs[j], '0, '0, 1'b1, 1'b0);
            checkOutput("fill_rd_a", dout_a, FILL_A);
            checkOutput("fill_rd_c", 32'(dout_c), 32'hA5);
            checkOutput("fill_vld_c", 32'(vld_c), 32'h1);
        end
        idleCycles(1, 1'b1);
        checkOutput("vld_pulse_c", 32'(vld_c), 32'h0);

        // Normal-mode write leaves dout alone, read returns the new byte
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 32'h3C, 4'h1, 1'b1, 1'b0);
        checkOutput("wr_hold_c", 32'(dout_c), 32'hA5);
        checkOutput("wr_novld_c", 32'(vld_c), 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h10, '0, '0, 1'b1, 1'b0);
        checkOutput("rd_new_c", 32'(dout_c), 32'h3C);
        idleCycles(1, 1'b1);
        checkOutput("rd_pulse_c", 32'(vld_c), 32'h0);

        // Read-before-write with partial byte enables
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 32'h1122_3344, 4'hF, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h05, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0);
        checkOutput("rbw_old_a", dout_a, 32'h1122_3344);
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h05, '0, '0, 1'b1, 1'b0);
        checkOutput("rbw_merge_a", dout_a, 32'h11BB_33DD);

        // Write-through with the pipelined output register and oce gating
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h03, 32'h5A, 4'hF, 1'b1, 1'b0);
        idleCycles(1, 1'b1);
        checkOutput("wt_lat2_b", dout_b, 32'h5A);
        applyStimulus(1'b1, 1'b1, 1'b1, 8'h03, 32'h77, 4'hF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            idleCycles(1, 1'b0);
            checkOutput("oce_hold_b", dout_b, 32'h5A);
        end
        idleCycles(1, 1'b1);
        checkOutput("oce_load_b", dout_b, 32'h77);
        checkOutput("oce_vld_b", 32'(vld_b), 32'h1);

        // Reset mid-pass restarts the auto fill from address 0
        applyStimulus(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b1);
        idleCycles(99, 1'b1);
        busy_cnt_a = 0;
        applyStimulus(1'b0, 1'b1, 1'b0, '0, '0, '0, 1'b1, 1'b0);
        checkOutput("rst_mid_dout_a", dout_a, 32'h0);
        checkOutput("rst_mid_vld_a", 32'(vld_a), 32'h0);
        checkOutput("rst_mid_busy_b", 32'(busy_b), 32'h0);
        for (int i = 0; i < 3 * DEPTH && busy_a; i++)
            idleCycles(1, 1'b1);
        checkOutput("refill_len_a", 32'(busy_cnt_a), 32'(DEPTH));

        // Random traffic
        for (int i = 0; i < 2000; i++)
            applyStimulus(($urandom_range(399) != 0), 1'($urandom), 1'($urandom),
                          ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15)),
                          $urandom, 4'($urandom), ($urandom_range(3) != 0),
                          ($urandom_range(99) == 0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sp_ram_param.md
Name: sp_ram_param

Overview:
- Parametrised single-port synchronous RAM, successor to the fixed 256x8 single-port BSRAM wrapper.
- Adds generic width and depth, selectable read and write modes, and byte-enable writes.
- Adds a built-in fill engine that writes FILL_VALUE to every word after reset or on request.
- Used as a general scratch/table buffer behind MCU-facing FPGA interfaces.

Parameters:
- DATA_W, 8, data width in bits; must be a multiple of 8.
- ADDR_W, 8, address width; DEPTH = 2**ADDR_W words.
- READ_MODE, 0, 0 = bypass (1-cycle read latency), 1 = pipeline (2-cycle latency, output register gated by oce).
- WRITE_MODE, 0, 0 = normal (dout holds on write), 1 = write-through (dout = newly written word), 2 = read-before-write (dout = old word).
- FILL_VALUE, 0, word written to every address by the fill engine.
- AUTO_FILL, 1, 1 = fill engine runs automatically after reset; 0 = fill only on fill_req.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- ce  in  1  access enable; ignored while busy=1.
- wre  in  1  1 = write, 0 = read; qualified by ce.
- ad  in  ADDR_W  word address.
- din  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i selects din[8i+7:8i].
- oce  in  1  output-register clock enable (READ_MODE=1 only).
- fill_req  in  1  single-cycle request to start a fill pass.
- dout  out  DATA_W  read data.
- dout_vld  out  1  one-cycle pulse when dout is updated by an access.
- busy  out  1  fill engine active.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - dout=0, dout_vld=0, the pipeline stage register and its valid flag are cleared, fill address = 0.
  - State becomes FILL if AUTO_FILL=1, otherwise IDLE.
  - RAM contents are not reset.
  - Reset asserted during FILL aborts the pass; if AUTO_FILL=1 the fill restarts from address 0.
- FSM states: IDLE and FILL.
  - IDLE -> FILL: on fill_req=1 sampled in IDLE.
  - In FILL, each cycle writes FILL_VALUE (all bytes) to the fill address, then increments it.
  - FILL -> IDLE: after the write to address DEPTH-1.
  - A pass takes exactly DEPTH cycles with busy=1; busy deasserts on the edge that performs the last write.
  - fill_req during FILL is ignored; the pass does not restart.
  - A fill_req that coincides with a user access in IDLE: the access is performed, and FILL starts next cycle.
- busy=1 rule: ce/wre/ad/din/be are ignored, no user access occurs, and dout holds its value.
  - In READ_MODE=1, the output register still honours oce, so a read captured before the fill can drain out.
- Read (IDLE, ce=1, wre=0):
  - Stage-1 data = mem[ad] at the next edge.
  - READ_MODE=0: dout = stage-1 data, with dout_vld=1 for one cycle (latency 1).
  - READ_MODE=1: the stage-1 register and its valid flag update on ce; dout and dout_vld load from stage 1 on the edge where oce=1 (latency 2 with oce held high).
  - READ_MODE=1 with oce=0: dout and dout_vld hold; dout_vld is forced to 0 after one pulse.
- Write (IDLE, ce=1, wre=1):
  - mem[ad] byte i is replaced by din byte i wherever be[i]=1; other bytes are kept.
  - be=0 leaves the word unchanged but still produces the stage-1 output per WRITE_MODE.
  - WRITE_MODE=0: stage 1 holds its value and no valid is generated.
  - WRITE_MODE=1: stage 1 = the merged new word, valid=1.
  - WRITE_MODE=2: stage 1 = the previous mem[ad], valid=1.
  - Stage 1 feeds dout as for reads (same latency rules per READ_MODE).
- ce=0: no memory access and no valid; stage 1 holds.
- Back-to-back accesses are supported every cycle, with full throughput and no bubbles.
- Addresses wrap naturally: DEPTH=2**ADDR_W, so all ad values are legal.
- Implementation must infer the vendor block RAM; a byte-lane write-enable per lane is allowed.

Test Plan:
- DATA_W=8, ADDR_W=8, AUTO_FILL=1, FILL_VALUE=8'hA5, reset pulse -> busy=1 for exactly 256 cycles; then reads of ad=0x00, 0x7F, 0xFF each return 0xA5 with dout_vld one cycle later.
- READ_MODE=0, WRITE_MODE=0: write ad=0x10 din=0x3C be=1 then read 0x10 -> dout unchanged during the write; dout=0x3C one cycle after the read, dout_vld a single pulse.
- DATA_W=32, WRITE_MODE=2: word 0x11223344 at ad=5, write din=0xAABBCCDD be=4'b0101 -> dout=0x11223344 (old); a subsequent read returns 0x11BB33DD.
- WRITE_MODE=1, READ_MODE=1: write ad=3 din=0x5A with oce=1 -> dout=0x5A two cycles after the write; repeat with oce=0 for 3 cycles then oce=1 -> dout changes only on the oce edge.
- Issue fill_req in IDLE, then assert ce reads plus a second fill_req mid-pass -> reads ignored, dout stable, no restart, busy low after exactly DEPTH cycles.
- Assert reset_n=0 at fill address 100 -> next pass restarts at address 0 and takes a full DEPTH cycles; dout=0 and dout_vld=0 immediately after reset.
